// File: rtl/cellram_arbiter.sv
// rtl/cellram_arbiter.sv - two-port command/data scheduler in front of cellram_interface
// Tie-break: CELLRAM_ARB_RR_EN selects round-robin; otherwise port 0 has fixed priority.
module cellram_arbiter #(
    parameter int Nb      = 16,
    parameter int Nb_addr = 23,
    parameter int Nb_bl   = 6,
    parameter int Nb_inst = 3
) (
    input  logic               clk_core,
    input  logic               reset_n,

    input  logic               p0_cmd_valid,
    output logic               p0_cmd_ready,
    input  logic [Nb_bl-1:0]   p0_cmd_bl,
    input  logic [Nb_inst-1:0] p0_cmd_instr,
    input  logic [Nb_addr-1:0] p0_cmd_addr,
    input  logic [Nb-1:0]      p0_wr_data,
    input  logic               p0_wr_valid,
    output logic               p0_wr_ready,
    output logic [Nb-1:0]      p0_rd_data,
    output logic               p0_rd_valid,
    input  logic               p0_rd_ready,

    input  logic               p1_cmd_valid,
    output logic               p1_cmd_ready,
    input  logic [Nb_bl-1:0]   p1_cmd_bl,
    input  logic [Nb_inst-1:0] p1_cmd_instr,
    input  logic [Nb_addr-1:0] p1_cmd_addr,
    input  logic [Nb-1:0]      p1_wr_data,
    input  logic               p1_wr_valid,
    output logic               p1_wr_ready,
    output logic [Nb-1:0]      p1_rd_data,
    output logic               p1_rd_valid,
    input  logic               p1_rd_ready,

    output logic [Nb_bl-1:0]   mem_cmd_bl,
    output logic [Nb_inst-1:0] mem_cmd_instr,
    output logic [Nb_addr-1:0] mem_cmd_addr,
    output logic               mem_cmd_valid,
    input  logic               mem_cmd_ready,
    output logic [Nb-1:0]      mem_wr_data,
    output logic               mem_wr_valid,
    input  logic               mem_wr_ready,
    input  logic [Nb-1:0]      mem_rd_data,
    input  logic               mem_rd_valid,
    output logic               mem_rd_ready,

    output logic               grant,
    output logic               busy,
    output logic               cmd_err
);

    localparam logic [Nb_inst-1:0] INSTR_WRITE = Nb_inst'(0);
    localparam logic [Nb_inst-1:0] INSTR_READ  = Nb_inst'(1);
    localparam logic [Nb_bl:0]     CNT_ONE     = (Nb_bl+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WDATA,
        S_WCMD,
        S_RCMD,
        S_RDATA
    } state_t;

    state_t               state_q;
    logic                 grant_q;
    logic                 busy_q;
    logic                 cmd_err_q;
    logic                 mem_cmd_valid_q;
    logic [Nb_bl-1:0]     bl_q;
    logic [Nb_inst-1:0]   instr_q;
    logic [Nb_addr-1:0]   addr_q;
    logic [Nb_bl:0]       word_cnt_q;

    logic                 cand;
    logic                 cmd_hs;
    logic                 in_wdata;
    logic                 in_rdata;
    logic                 wr_hs;
    logic                 rd_hs;
    logic                 last_word;
    logic [Nb_bl-1:0]     sel_bl;
    logic [Nb_inst-1:0]   sel_instr;
    logic [Nb_addr-1:0]   sel_addr;

`ifdef CELLRAM_ARB_RR_EN
    logic                 last_q;

    // On a tie the port that was not served last goes first.
    always_comb begin
        cand = 1'b0;
        if (p0_cmd_valid && p1_cmd_valid) begin
            cand = ~last_q;
        end else if (p1_cmd_valid) begin
            cand = 1'b1;
        end
    end
`else
    assign cand = ~p0_cmd_valid & p1_cmd_valid;
`endif

    assign cmd_hs       = (state_q == S_IDLE) && (p0_cmd_valid || p1_cmd_valid);
    assign p0_cmd_ready = (state_q == S_IDLE) && !cand;
    assign p1_cmd_ready = (state_q == S_IDLE) &&  cand;

    assign sel_bl    = cand ? p1_cmd_bl    : p0_cmd_bl;
    assign sel_instr = cand ? p1_cmd_instr : p0_cmd_instr;
    assign sel_addr  = cand ? p1_cmd_addr  : p0_cmd_addr;

    assign in_wdata = (state_q == S_WDATA);
    assign in_rdata = (state_q == S_RDATA);

    // Data paths are pure pass-through so a granted port streams at one word per cycle.
    assign mem_wr_valid = in_wdata && (grant_q ? p1_wr_valid : p0_wr_valid);
    assign mem_wr_data  = grant_q ? p1_wr_data : p0_wr_data;
    assign p0_wr_ready  = in_wdata && !grant_q && mem_wr_ready;
    assign p1_wr_ready  = in_wdata &&  grant_q && mem_wr_ready;

    assign mem_rd_ready = in_rdata && (grant_q ? p1_rd_ready : p0_rd_ready);
    assign p0_rd_valid  = in_rdata && !grant_q && mem_rd_valid;
    assign p1_rd_valid  = in_rdata &&  grant_q && mem_rd_valid;
    assign p0_rd_data   = mem_rd_data;
    assign p1_rd_data   = mem_rd_data;

    assign wr_hs     = mem_wr_valid && mem_wr_ready;
    assign rd_hs     = mem_rd_valid && mem_rd_ready;
    assign last_word = (word_cnt_q == {1'b0, bl_q});

    assign mem_cmd_valid = mem_cmd_valid_q;
    assign mem_cmd_bl    = bl_q;
    assign mem_cmd_instr = instr_q;
    assign mem_cmd_addr  = addr_q;
    assign grant         = grant_q;
    assign busy          = busy_q;
    assign cmd_err       = cmd_err_q;

    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= S_IDLE;
            grant_q         <= 1'b0;
            busy_q          <= 1'b0;
            cmd_err_q       <= 1'b0;
            mem_cmd_valid_q <= 1'b0;
            bl_q            <= '0;
            instr_q         <= '0;
            addr_q          <= '0;
            word_cnt_q      <= '0;
`ifdef CELLRAM_ARB_RR_EN
            last_q          <= 1'b1;
`endif
        end else begin
            cmd_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_hs) begin
                        grant_q    <= cand;
                        bl_q       <= sel_bl;
                        instr_q    <= sel_instr;
                        addr_q     <= sel_addr;
                        word_cnt_q <= '0;
`ifdef CELLRAM_ARB_RR_EN
                        last_q     <= cand;
`endif
                        if (sel_instr == INSTR_WRITE) begin
                            state_q <= S_WDATA;
                            busy_q  <= 1'b1;
                        end else if (sel_instr == INSTR_READ) begin
                            state_q         <= S_RCMD;
                            busy_q          <= 1'b1;
                            mem_cmd_valid_q <= 1'b1;
                        end else begin
                            cmd_err_q <= 1'b1;
                        end
                    end
                end
                // Write data is queued in full before the command is presented.
                S_WDATA: begin
                    if (wr_hs) begin
                        word_cnt_q <= word_cnt_q + CNT_ONE;
                        if (last_word) begin
                            state_q         <= S_WCMD;
                            mem_cmd_valid_q <= 1'b1;
                        end
                    end
                end
                S_WCMD: begin
                    if (mem_cmd_ready) begin
                        mem_cmd_valid_q <= 1'b0;
                        state_q         <= S_IDLE;
                        busy_q          <= 1'b0;
                    end
                end
                S_RCMD: begin
                    if (mem_cmd_ready) begin
                        mem_cmd_valid_q <= 1'b0;
                        state_q         <= S_RDATA;
                    end
                end
                S_RDATA: begin
                    if (rd_hs) begin
                        word_cnt_q <= word_cnt_q + CNT_ONE;
                        if (last_word) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q         <= S_IDLE;
                    busy_q          <= 1'b0;
                    mem_cmd_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cellram_arbiter.sv
// tb/tb_cellram_arbiter.sv - randomized scoreboard bench for cellram_arbiter
module tb_cellram_arbiter;

    localparam int NB  = 16;
    localparam int NA  = 23;
    localparam int NBL = 6;
    localparam int NI  = 3;

    logic clk_core = 1'b0;
    always #5 clk_core = ~clk_core;

    logic           reset_n;
    logic [1:0]     cmd_valid, wr_valid, rd_ready;
    logic [NBL-1:0] cmd_bl    [2];
    logic [NI-1:0]  cmd_instr [2];
    logic [NA-1:0]  cmd_addr  [2];
    logic [NB-1:0]  wr_data   [2];
    wire  [1:0]     cmd_ready, wr_ready, rd_valid;
    wire  [NB-1:0]  rd_data0, rd_data1;

    wire  [NBL-1:0] mem_cmd_bl;
    wire  [NI-1:0]  mem_cmd_instr;
    wire  [NA-1:0]  mem_cmd_addr;
    wire            mem_cmd_valid, mem_wr_valid, mem_rd_ready;
    wire  [NB-1:0]  mem_wr_data;
    logic           mem_cmd_ready, mem_wr_ready, mem_rd_valid;
    logic [NB-1:0]  mem_rd_data;
    wire            grant, busy, cmd_err;

    cellram_arbiter #(.Nb(NB), .Nb_addr(NA), .Nb_bl(NBL), .Nb_inst(NI)) dut (
        .clk_core(clk_core), .reset_n(reset_n),
        .p0_cmd_valid(cmd_valid[0]), .p0_cmd_ready(cmd_ready[0]), .p0_cmd_bl(cmd_bl[0]),
        .p0_cmd_instr(cmd_instr[0]), .p0_cmd_addr(cmd_addr[0]), .p0_wr_data(wr_data[0]),
        .p0_wr_valid(wr_valid[0]), .p0_wr_ready(wr_ready[0]), .p0_rd_data(rd_data0),
        .p0_rd_valid(rd_valid[0]), .p0_rd_ready(rd_ready[0]),
        .p1_cmd_valid(cmd_valid[1]), .p1_cmd_ready(cmd_ready[1]), .p1_cmd_bl(cmd_bl[1]),
        .p1_cmd_instr(cmd_instr[1]), .p1_cmd_addr(cmd_addr[1]), .p1_wr_data(wr_data[1]),
        .p1_wr_valid(wr_valid[1]), .p1_wr_ready(wr_ready[1]), .p1_rd_data(rd_data1),
        .p1_rd_valid(rd_valid[1]), .p1_rd_ready(rd_ready[1]),
        .mem_cmd_bl(mem_cmd_bl), .mem_cmd_instr(mem_cmd_instr), .mem_cmd_addr(mem_cmd_addr),
        .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
        .mem_wr_data(mem_wr_data), .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
        .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid), .mem_rd_ready(mem_rd_ready),
        .grant(grant), .busy(busy), .cmd_err(cmd_err)
    );

    typedef struct packed {
        logic           p;
        logic [NBL-1:0] bl;
        logic [NI-1:0]  instr;
        logic [NA-1:0]  addr;
    } cmd_t;

    typedef struct packed {
        logic          p;
        logic [NB-1:0] d;
    } word_t;

    cmd_t          exp_cmd [$];
    word_t         exp_wr  [$];
    word_t         exp_rd  [$];
    logic          exp_err [$];
    logic [NB-1:0] memq    [$];
    int            pend;
    int            stall;
    int            rd_seen;
    int            checks = 0;
    int            errors = 0;

    logic [NBL-1:0] t_bl    [2];
    logic [NI-1:0]  t_instr [2];
    logic [NA-1:0]  t_addr  [2];
    logic [NB-1:0]  wdat    [2][64];
    logic [NB-1:0]  rdat    [2][64];

`ifdef CELLRAM_ARB_RR_EN
    bit last_srv = 1'b1;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_ev(input string msg);
        checks++;
        errors++;
        $display("FAIL %s", msg);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " grant"}, 64'(grant), 64'd0);
        chk({tag, " busy"}, 64'(busy), 64'd0);
        chk({tag, " cmd_err"}, 64'(cmd_err), 64'd0);
        chk({tag, " mem_cmd_valid"}, 64'(mem_cmd_valid), 64'd0);
        chk({tag, " mem_cmd_fields"}, 64'({mem_cmd_bl, mem_cmd_instr, mem_cmd_addr}), 64'd0);
        chk({tag, " mem_wr_valid"}, 64'(mem_wr_valid), 64'd0);
        chk({tag, " mem_rd_ready"}, 64'(mem_rd_ready), 64'd0);
        chk({tag, " rd_valid"}, 64'(rd_valid), 64'd0);
        chk({tag, " wr_ready"}, 64'(wr_ready), 64'd0);
        chk({tag, " p1_cmd_ready"}, 64'(cmd_ready[1]), 64'd0);
    endtask

    // Reference model: what one accepted command from port p must produce, in service order.
    task automatic expect_txn(input int p);
        cmd_t c;
        word_t w;
        c.p = 1'(p);
        c.bl = t_bl[p];
        c.instr = t_instr[p];
        c.addr = t_addr[p];
        if (t_instr[p] == 3'd0) begin
            for (int i = 0; i <= int'(t_bl[p]); i++) begin
                w.p = 1'(p);
                w.d = wdat[p][i];
                exp_wr.push_back(w);
            end
            exp_cmd.push_back(c);
        end else if (t_instr[p] == 3'd1) begin
            exp_cmd.push_back(c);
            for (int i = 0; i <= int'(t_bl[p]); i++) begin
                w.p = 1'(p);
                w.d = rdat[p][i];
                memq.push_back(w.d);
                exp_rd.push_back(w);
            end
        end else begin
            exp_err.push_back(1'(p));
        end
`ifdef CELLRAM_ARB_RR_EN
        last_srv = 1'(p);
`endif
    endtask

    task automatic gen_txn(input int p, input int isel, input int bsel);
        int r;
        if (isel >= 0) begin
            t_instr[p] = NI'(isel);
        end else begin
            r = $urandom_range(0, 9);
            t_instr[p] = (r < 5) ? 3'd0 : (r < 9) ? 3'd1 : NI'($urandom_range(2, 7));
        end
        if (bsel >= 0) t_bl[p] = NBL'(bsel);
        else if ($urandom_range(0, 7) == 0) t_bl[p] = NBL'($urandom_range(0, 63));
        else t_bl[p] = NBL'($urandom_range(0, 7));
        t_addr[p] = NA'($urandom());
        for (int i = 0; i < 64; i++) begin
            wdat[p][i] = NB'($urandom());
            rdat[p][i] = NB'($urandom());
        end
    endtask

    task automatic drive_port(input int p);
        int  n;
        int  guard;
        bit  hs;
        cmd_bl[p] = t_bl[p];
        cmd_instr[p] = t_instr[p];
        cmd_addr[p] = t_addr[p];
        cmd_valid[p] = 1'b1;
        guard = 0;
        do begin
            @(negedge clk_core);
            hs = cmd_ready[p];
            @(posedge clk_core);
            #1;
            guard++;
        end while (!hs && guard < 4000);
        cmd_valid[p] = 1'b0;
        if (!hs) begin
            fail_ev($sformatf("cmd_timeout port %0d: got no cmd_ready, expected handshake", p));
            return;
        end
        n = 0;
        guard = 0;
        if (t_instr[p] == 3'd0) begin
            while (n <= int'(t_bl[p]) && guard < 4000) begin
                wr_data[p] = wdat[p][n];
                wr_valid[p] = ($urandom_range(0, 3) != 0);
                @(negedge clk_core);
                hs = wr_valid[p] && wr_ready[p];
                @(posedge clk_core);
                #1;
                guard++;
                if (hs) n++;
            end
            wr_valid[p] = 1'b0;
        end else if (t_instr[p] == 3'd1) begin
            while (n <= int'(t_bl[p]) && guard < 4000) begin
                rd_ready[p] = ($urandom_range(0, 3) != 0);
                @(negedge clk_core);
                hs = rd_valid[p] && rd_ready[p];
                @(posedge clk_core);
                #1;
                guard++;
                if (hs) n++;
            end
            rd_ready[p] = 1'b0;
        end
        if (guard >= 4000)
            fail_ev($sformatf("data_timeout port %0d: got %0d words, expected %0d", p, n, int'(t_bl[p]) + 1));
    endtask

    task automatic drain();
        int guard = 0;
        while ((exp_cmd.size() != 0 || exp_wr.size() != 0 || exp_rd.size() != 0 ||
                exp_err.size() != 0 || busy) && guard < 500) begin
            @(negedge clk_core);
            guard++;
        end
        checks++;
        if (guard >= 500) begin
            errors++;
            $display("FAIL drain: got %0d cmd/%0d wr/%0d rd/%0d err outstanding, expected none",
                     exp_cmd.size(), exp_wr.size(), exp_rd.size(), exp_err.size());
            exp_cmd.delete(); exp_wr.delete(); exp_rd.delete(); exp_err.delete();
        end
        repeat (2) @(posedge clk_core);
        #1;
    endtask

    task automatic run_round(input bit r0, input bit r1);
        int first;
        if (r0 && r1) begin
            first = 0;
`ifdef CELLRAM_ARB_RR_EN
            first = last_srv ? 0 : 1;
`endif
            expect_txn(first);
            expect_txn(1 - first);
        end else if (r0) begin
            expect_txn(0);
        end else begin
            expect_txn(1);
        end
        fork
            if (r0) drive_port(0);
            if (r1) drive_port(1);
        join
        drain();
    endtask

    // Memory-side responder standing in for cellram_interface.
    initial begin
        bit ch, crd, rh;
        int cbl;
        mem_cmd_ready = 1'b0;
        mem_wr_ready = 1'b0;
        mem_rd_valid = 1'b0;
        mem_rd_data = '0;
        pend = 0;
        stall = 0;
        forever begin
            @(negedge clk_core);
            ch = mem_cmd_valid && mem_cmd_ready;
            crd = (mem_cmd_instr == 3'd1);
            cbl = int'(mem_cmd_bl);
            rh = mem_rd_valid && mem_rd_ready;
            @(posedge clk_core);
            #1;
            if (rh && pend > 0) begin
                pend--;
                if (memq.size() > 0) void'(memq.pop_front());
            end
            if (ch && crd) pend += cbl + 1;
            if (stall > 0) begin
                mem_cmd_ready = 1'b0;
                stall--;
            end else if ($urandom_range(0, 9) == 0) begin
                mem_cmd_ready = 1'b0;
                stall = 5;
            end else begin
                mem_cmd_ready = ($urandom_range(0, 3) != 0);
            end
            mem_wr_ready = ($urandom_range(0, 4) != 0);
            if (pend > 0 && memq.size() > 0) begin
                mem_rd_data = memq[0];
                mem_rd_valid = ($urandom_range(0, 3) != 0);
            end else begin
                mem_rd_valid = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on every handshake the DUT presents.
    initial begin
        cmd_t    ec;
        word_t   ew;
        logic    ep;
        logic    pv, pr;
        logic [32:0] pf;
        int      rd_left, own;
        bit      chk_idle;
        pv = 1'b0; pr = 1'b0; pf = '0; rd_left = 0; chk_idle = 1'b0; rd_seen = 0;
        forever begin
            @(negedge clk_core);
            if (!reset_n) begin
                pv = 1'b0; rd_left = 0; chk_idle = 1'b0;
                continue;
            end
            if (chk_idle) begin
                chk("busy_after_txn", 64'(busy), 64'd0);
                chk_idle = 1'b0;
            end
            if (pv && !pr)
                chk("cmd_hold", 64'({mem_cmd_valid, grant, mem_cmd_bl, mem_cmd_instr, mem_cmd_addr}),
                    64'({1'b1, pf}));
            if (busy) chk("cmd_ready_while_busy", 64'(cmd_ready), 64'd0);
            for (int p = 0; p < 2; p++)
                if (rd_valid[p]) chk($sformatf("rd_valid%0d_grant", p), 64'(grant), 64'(p));
            if (mem_cmd_valid && mem_cmd_ready) begin
                if (exp_cmd.size() == 0) begin
                    fail_ev($sformatf("mem_cmd: got unexpected cmd instr %0d, expected none", mem_cmd_instr));
                end else begin
                    ec = exp_cmd.pop_front();
                    chk("mem_cmd", 64'({grant, mem_cmd_bl, mem_cmd_instr, mem_cmd_addr}), 64'(ec));
                    own = 0;
                    foreach (exp_wr[i]) if (exp_wr[i].p == ec.p) own++;
                    chk("wdata_before_cmd", 64'(own), 64'd0);
                    if (ec.instr == 3'd0) chk_idle = 1'b1;
                    else rd_left = int'(ec.bl) + 1;
                end
            end
            if (mem_wr_valid && mem_wr_ready) begin
                if (exp_wr.size() == 0) begin
                    fail_ev($sformatf("mem_wr: got unexpected word 0x%0h, expected none", mem_wr_data));
                end else begin
                    ew = exp_wr.pop_front();
                    chk("mem_wr", 64'({grant, mem_wr_data}), 64'(ew));
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (rd_valid[p] && rd_ready[p]) begin
                    rd_seen++;
                    if (exp_rd.size() == 0) begin
                        fail_ev($sformatf("rd%0d: got unexpected word, expected none", p));
                    end else begin
                        ew = exp_rd.pop_front();
                        chk($sformatf("rd_port%0d", p), 64'({1'(p), p ? rd_data1 : rd_data0}), 64'(ew));
                        rd_left--;
                        if (rd_left == 0) chk_idle = 1'b1;
                    end
                end
            end
            if (cmd_err) begin
                if (exp_err.size() == 0) begin
                    fail_ev("cmd_err: got pulse, expected none");
                end else begin
                    ep = exp_err.pop_front();
                    chk("cmd_err_port", 64'(grant), 64'(ep));
                end
            end
            pv = mem_cmd_valid;
            pr = mem_cmd_ready;
            pf = {grant, mem_cmd_bl, mem_cmd_instr, mem_cmd_addr};
        end
    end

    task automatic reset_test();
        int  guard;
        int  base;
        bit  hs;
        gen_txn(0, 1, 7);
        expect_txn(0);
        base = rd_seen;
        cmd_bl[0] = t_bl[0];
        cmd_instr[0] = t_instr[0];
        cmd_addr[0] = t_addr[0];
        cmd_valid[0] = 1'b1;
        rd_ready[0] = 1'b1;
        guard = 0;
        hs = 1'b0;
        while (rd_seen < base + 2 && guard < 500) begin
            @(negedge clk_core);
            if (cmd_ready[0]) hs = 1'b1;
            #1;
            guard++;
            if (rd_seen < base + 2) begin
                @(posedge clk_core);
                #1;
                if (hs) cmd_valid[0] = 1'b0;
            end
        end
        if (guard >= 500) fail_ev("reset_test: got fewer than 2 read words, expected 2 before reset");
        @(posedge clk_core);
        #2;
        reset_n = 1'b0;
        cmd_valid[0] = 1'b0;
        rd_ready[0] = 1'b0;
        #1;
        check_reset("mid_rdata_reset");
        exp_cmd.delete(); exp_rd.delete(); exp_wr.delete(); exp_err.delete();
        memq.delete();
        pend = 0;
`ifdef CELLRAM_ARB_RR_EN
        last_srv = 1'b1;
`endif
        @(negedge clk_core);
        reset_n = 1'b1;
        @(posedge clk_core);
        #1;
    endtask

    initial begin
        cmd_valid = '0;
        wr_valid = '0;
        rd_ready = '0;
        for (int p = 0; p < 2; p++) begin
            cmd_bl[p] = '0; cmd_instr[p] = '0; cmd_addr[p] = '0; wr_data[p] = '0;
        end
        reset_n = 1'b0;
        repeat (3) @(posedge clk_core);
        #1;
        check_reset("reset");
        reset_n = 1'b1;
        @(posedge clk_core);
        #1;

        gen_txn(0, 0, 3);
        t_addr[0] = 23'h000100;
        for (int i = 0; i < 4; i++) wdat[0][i] = NB'(16'h00A0 + i);
        run_round(1'b1, 1'b0);

        gen_txn(1, 1, 1);
        rdat[1][0] = 16'h1234;
        rdat[1][1] = 16'h5678;
        run_round(1'b0, 1'b1);

        repeat (4) begin
            gen_txn(0, 1, -1);
            gen_txn(1, 1, -1);
            run_round(1'b1, 1'b1);
        end

        gen_txn(0, 5, 2);
        run_round(1'b1, 1'b0);

        gen_txn(0, 1, 63);
        gen_txn(1, 0, 63);
        run_round(1'b1, 1'b1);

        repeat (60) begin
            bit r0, r1;
            gen_txn(0, -1, -1);
            gen_txn(1, -1, -1);
            r0 = ($urandom_range(0, 2) != 0);
            r1 = ($urandom_range(0, 2) != 0);
            if (!r0 && !r1) r0 = 1'b1;
            run_round(r0, r1);
        end

        reset_test();

        gen_txn(0, 0, 2);
        gen_txn(1, 1, 2);
        run_round(1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
